aes_req_sched: RTL and testbench

Controller for the single shared `aes_128` engine in the sensor node. It arbitrates round-robin between the encrypt requester (sensor TX path, port s0) and the decrypt requester (radio RX path, port s1). It owns the 128-bit session key register, drives the core's inputs, waits out the core latency, and returns each result with a tag identifying the requester. One block is in flight at a time.

---
 rtl/aes_req_sched.sv | 178 +++++++++++++++++
 tb/tb_aes_req_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_sched.sv
// aes_req_sched: request scheduler and key owner for the shared aes_128 core.
//
// This block arbitrates round-robin between the encrypt requester (s0) and the
// decrypt requester (s1). It holds the session key and drives the core inputs.
// It waits out the core latency, then returns the result tagged with the
// requester id. Only one block is in flight at any time.
//
// Optional feature macro: AES_SCHED_STATS_EN
//   defined   -> 16-bit saturating result counters per requester
//   undefined -> cnt_enc / cnt_dec tied to 0, no counter logic
//
// State table
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | key writes accepted; otherwise grant one requester
//   ST_RUN  | block held on core inputs; wait_q counts down the core latency
//   ST_RESP | result presented on m_*; waiting for m_ready
module aes_req_sched #(
   parameter int unsigned CORE_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic         key_ready,
   input  logic         s0_valid,
   output logic         s0_ready,
   input  logic [127:0] s0_data,
   input  logic         s1_valid,
   output logic         s1_ready,
   input  logic [127:0] s1_data,
   output logic [127:0] core_data_in,
   output logic [127:0] core_key,
   output logic         core_enc_dec,
   input  logic [127:0] core_data_out,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [127:0] m_data,
   output logic         m_id,
   output logic         busy,
   output logic [15:0]  cnt_enc,
   output logic [15:0]  cnt_dec
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t        state_q;
   logic          last_id_q;
   logic          id_q;
   logic [127:0]  key_q;
   logic [127:0]  data_in_q;
   logic          enc_dec_q;
   logic [3:0]    wait_q;
   logic          m_valid_q;
   logic [127:0]  m_data_q;
   logic          m_id_q;

   logic          gnt_valid;
   logic          gnt_id;
   logic          accept;
   logic          res_hs;
   logic [127:0]  gnt_data;

   // Grant: a key write in IDLE blocks both requesters for that cycle; on a
   // tie the requester that was not served last wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = 1'b0;
      if (state_q == ST_IDLE && !key_load) begin
         if (s0_valid && s1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = ~last_id_q;
         end else if (s0_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b0;
         end else if (s1_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = 1'b1;
         end
      end
   end

   assign s0_ready = gnt_valid & ~gnt_id;
   assign s1_ready = gnt_valid &  gnt_id;
   assign accept   = (s0_valid & s0_ready) | (s1_valid & s1_ready);
   assign gnt_data = gnt_id ? s1_data : s0_data;
   assign res_hs   = (state_q == ST_RESP) & m_valid_q & m_ready;

   assign key_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign core_key     = key_q;
   assign core_data_in = data_in_q;
   assign core_enc_dec = enc_dec_q;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_id         = m_id_q;

   // Main sequencer: key load, accept, latency countdown and result handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         last_id_q <= 1'b1;
         id_q      <= 1'b0;
         key_q     <= '0;
         data_in_q <= '0;
         enc_dec_q <= 1'b0;
         wait_q    <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_id_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (key_load) begin
                  key_q <= key_in;
               end else if (accept) begin
                  data_in_q <= gnt_data;
                  enc_dec_q <= ~gnt_id;
                  id_q      <= gnt_id;
                  last_id_q <= gnt_id;
                  wait_q    <= 4'(CORE_LAT);
                  state_q   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (wait_q != 4'd0) begin
                  wait_q <= wait_q - 4'd1;
               end else begin
                  m_data_q  <= core_data_out;
                  m_id_q    <= id_q;
                  m_valid_q <= 1'b1;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (res_hs) begin
                  m_valid_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               m_valid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef AES_SCHED_STATS_EN
   logic [15:0] cnt_enc_q;
   logic [15:0] cnt_dec_q;

   // Per-requester result counters, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_enc_q <= '0;
         cnt_dec_q <= '0;
      end else if (res_hs) begin
         if (!m_id_q) begin
            if (cnt_enc_q != 16'hFFFF) cnt_enc_q <= cnt_enc_q + 16'd1;
         end else begin
            if (cnt_dec_q != 16'hFFFF) cnt_dec_q <= cnt_dec_q + 16'd1;
         end
      end
   end

   assign cnt_enc = cnt_enc_q;
   assign cnt_dec = cnt_dec_q;
`else
   assign cnt_enc = 16'd0;
   assign cnt_dec = 16'd0;
`endif

endmodule

// File: tb/tb_aes_req_sched.sv
// Bench for aes_req_sched: the core is modelled as a registered XOR with
// latency LAT. A transaction-level reference model predicts the handshakes
// and results from the scheduling rules.
module tb_aes_req_sched;
   localparam int LAT = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] key_in = '0;
   logic         key_load = 1'b0;
   logic         key_ready;
   logic         s0_valid = 1'b0, s1_valid = 1'b0;
   logic         s0_ready, s1_ready;
   logic [127:0] s0_data = '0, s1_data = '0;
   logic [127:0] core_data_in, core_key, core_data_out;
   logic         core_enc_dec;
   logic         m_valid, m_id, busy;
   logic         m_ready = 1'b0;
   logic [127:0] m_data;
   logic [15:0]  cnt_enc, cnt_dec;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   aes_req_sched #(.CORE_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_ready(key_ready),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
      .core_data_in(core_data_in), .core_key(core_key), .core_enc_dec(core_enc_dec),
      .core_data_out(core_data_out), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_id(m_id), .busy(busy), .cnt_enc(cnt_enc), .cnt_dec(cnt_dec)
   );

   always #5 clk = ~clk;

   // Behavioural core: XOR of block and key through LAT register stages.
   logic [127:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= core_data_in ^ core_key;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign core_data_out = pipe[LAT-1];

   // Reference model: phase 0 idle, 1 waiting on core, 2 result offered.
   int           ph;
   int           left;
   bit           mdl_last;
   bit           mdl_id;
   bit           mdl_enc;
   logic [127:0] mdl_key, mdl_res, mdl_din;
   int           mdl_ce, mdl_cd;
   bit           exp_r0, exp_r1, exp_kr, exp_busy, exp_mv;
   logic [15:0]  exp_ce, exp_cd;

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_reset();
      ph = 0; left = 0; mdl_last = 1'b1; mdl_id = 1'b0; mdl_enc = 1'b0;
      mdl_key = '0; mdl_res = '0; mdl_din = '0; mdl_ce = 0; mdl_cd = 0;
   endtask

   // Apply one cycle of inputs and compute what the outputs should be now.
   task automatic drive(input bit v0, input bit v1, input logic [127:0] d0,
                        input logic [127:0] d1, input bit kl,
                        input logic [127:0] ki, input bit mr);
      s0_valid = v0; s1_valid = v1; s0_data = d0; s1_data = d1;
      key_load = kl; key_in = ki; m_ready = mr;
      #1;
      exp_kr = (ph == 0);
      exp_busy = (ph != 0);
      exp_mv = (ph == 2);
      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      if (ph == 0 && !kl) begin
         if (v0 && v1) begin
            if (mdl_last) exp_r0 = 1'b1;
            else exp_r1 = 1'b1;
         end else if (v0) exp_r0 = 1'b1;
         else if (v1) exp_r1 = 1'b1;
      end
`ifdef AES_SCHED_STATS_EN
      exp_ce = 16'(mdl_ce);
      exp_cd = 16'(mdl_cd);
`else
      exp_ce = 16'd0;
      exp_cd = 16'd0;
`endif
   endtask

   // Move the model across the coming clock edge and wait for the next negedge.
   task automatic advance();
      if (ph == 0) begin
         if (key_load) begin
            mdl_key = key_in;
         end else if (exp_r0 || exp_r1) begin
            mdl_id = exp_r1;
            mdl_last = exp_r1;
            mdl_enc = exp_r0;
            mdl_din = exp_r1 ? s1_data : s0_data;
            mdl_res = mdl_din ^ mdl_key;
            ph = 1;
            left = LAT + 1;
         end
      end else if (ph == 1) begin
         left--;
         if (left == 0) ph = 2;
      end else if (m_ready) begin
         ph = 0;
         if (!mdl_id) mdl_ce = (mdl_ce < 65535) ? mdl_ce + 1 : 65535;
         else mdl_cd = (mdl_cd < 65535) ? mdl_cd + 1 : 65535;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && ph != 0; i++) begin
         drive(0, 0, '0, '0, 0, '0, 1);
         advance();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s0_valid = 0; s1_valid = 0; key_load = 0; m_ready = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      drive(0, 0, '0, '0, 0, '0, 0);
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else n_pass++;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %0b exp 0", m_valid); else n_pass++;
      n_checks++; if (m_data !== '0) $display("FAIL rst_m_data got %h exp 0", m_data); else n_pass++;
      n_checks++; if (m_id !== 1'b0) $display("FAIL rst_m_id got %0b exp 0", m_id); else n_pass++;
      n_checks++; if (key_ready !== 1'b1) $display("FAIL rst_key_ready got %0b exp 1", key_ready); else n_pass++;
      n_checks++; if (core_key !== '0) $display("FAIL rst_core_key got %h exp 0", core_key); else n_pass++;
      n_checks++; if (core_data_in !== '0) $display("FAIL rst_core_data_in got %h exp 0", core_data_in); else n_pass++;
      n_checks++; if (core_enc_dec !== 1'b0) $display("FAIL rst_enc_dec got %0b exp 0", core_enc_dec); else n_pass++;
      n_checks++; if (cnt_enc !== 16'd0) $display("FAIL rst_cnt_enc got %0d exp 0", cnt_enc); else n_pass++;
      n_checks++; if (cnt_dec !== 16'd0) $display("FAIL rst_cnt_dec got %0d exp 0", cnt_dec); else n_pass++;
      advance();
   endtask

   task automatic test_single_encrypt();
      logic [127:0] k, pt, ct;
      k  = 128'h000102030405060708090A0B0C0D0E0F;
      pt = 128'h00112233445566778899AABBCCDDEEFF;
      ct = 128'h00102030405060708090A0B0C0D0E0F0;
      drive(0, 0, '0, '0, 1, k, 1);
      advance();
      n_checks++; if (core_key !== k) $display("FAIL se_key got %h exp %h", core_key, k); else n_pass++;
      drive(1, 0, pt, '0, 0, '0, 1);
      n_checks++; if (s0_ready !== 1'b1) $display("FAIL se_s0_ready got %0b exp 1", s0_ready); else n_pass++;
      advance();
      for (int k2 = 0; k2 <= LAT + 2; k2++) begin
         drive(0, 0, '0, '0, 0, '0, 1);
         n_checks++;
         if (m_valid !== (k2 == LAT + 1)) $display("FAIL se_m_valid edge %0d got %0b exp %0b", k2 + 1, m_valid, (k2 == LAT + 1));
         else n_pass++;
         if (k2 <= LAT) begin
            n_checks++; if (core_enc_dec !== 1'b1) $display("FAIL se_enc_dec got %0b exp 1", core_enc_dec); else n_pass++;
            n_checks++; if (core_data_in !== pt) $display("FAIL se_data_in got %h exp %h", core_data_in, pt); else n_pass++;
         end
         if (k2 == LAT + 1) begin
            n_checks++; if (m_data !== ct) $display("FAIL se_m_data got %h exp %h", m_data, ct); else n_pass++;
            n_checks++; if (m_id !== 1'b0) $display("FAIL se_m_id got %0b exp 0", m_id); else n_pass++;
         end
         advance();
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL se_idle_after got %0b exp 0", busy); else n_pass++;
   endtask

   task automatic test_contention();
      logic [127:0] d0, d1;
      int acc, last_cyc;
      bit took0, took1;
      do_reset();
      acc = 0; last_cyc = 0;
      d0 = rnd128(); d1 = rnd128();
      for (int c = 0; c < 100 && acc < 6; c++) begin
         drive(1, 1, d0, d1, 0, '0, 1);
         took0 = s0_ready; took1 = s1_ready;
         n_checks++; if (s0_ready !== exp_r0 || s1_ready !== exp_r1)
            $display("FAIL ct_ready got %0b%0b exp %0b%0b", s0_ready, s1_ready, exp_r0, exp_r1); else n_pass++;
         if (exp_mv) begin
            n_checks++; if (m_valid !== 1'b1 || m_data !== mdl_res || m_id !== mdl_id)
               $display("FAIL ct_result got v%0b %h id%0b exp %h id%0b", m_valid, m_data, m_id, mdl_res, mdl_id); else n_pass++;
         end
         if (took0 || took1) begin
            n_checks++; if (took1 !== (acc % 2 == 1))
               $display("FAIL ct_order grant %0d got s%0d exp s%0d", acc, took1, acc % 2); else n_pass++;
            if (acc > 0) begin
               n_checks++; if (cyc - last_cyc != LAT + 3)
                  $display("FAIL ct_period got %0d exp %0d", cyc - last_cyc, LAT + 3); else n_pass++;
            end
            last_cyc = cyc;
            acc++;
         end
         advance();
         if (took0) d0 = rnd128();
         if (took1) d1 = rnd128();
      end
      n_checks++; if (acc != 6) $display("FAIL ct_timeout got %0d grants exp 6", acc); else n_pass++;
      drain();
   endtask

   task automatic test_backpressure();
      logic [127:0] d;
      d = rnd128();
      drive(0, 1, '0, d, 0, '0, 0);
      n_checks++; if (s1_ready !== 1'b1) $display("FAIL bp_s1_ready got %0b exp 1", s1_ready); else n_pass++;
      advance();
      for (int i = 0; i < 20 && ph != 2; i++) begin
         drive(0, 0, '0, '0, 0, '0, 0);
         advance();
      end
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, rnd128(), rnd128(), 1, rnd128(), 0);
         n_checks++; if (m_valid !== 1'b1 || m_data !== (d ^ mdl_key) || m_id !== 1'b1)
            $display("FAIL bp_hold got v%0b %h id%0b exp v1 %h id1", m_valid, m_data, m_id, d ^ mdl_key); else n_pass++;
         n_checks++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || key_ready !== 1'b0)
            $display("FAIL bp_ready got %0b%0b%0b exp 000", s0_ready, s1_ready, key_ready); else n_pass++;
         n_checks++; if (busy !== 1'b1) $display("FAIL bp_busy got %0b exp 1", busy); else n_pass++;
         advance();
      end
      drive(0, 0, '0, '0, 0, '0, 1);
      n_checks++; if (m_valid !== 1'b1) $display("FAIL bp_release got %0b exp 1", m_valid); else n_pass++;
      advance();
      drive(0, 0, '0, '0, 0, '0, 1);
      n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL bp_done got v%0b busy%0b exp 00", m_valid, busy); else n_pass++;
      n_checks++; if (core_key !== mdl_key) $display("FAIL bp_key got %h exp %h", core_key, mdl_key); else n_pass++;
      advance();
   endtask

   task automatic test_key_collision();
      logic [127:0] nk, d, ok;
      nk = rnd128(); d = rnd128(); ok = rnd128();
      drive(1, 0, d, '0, 1, nk, 1);
      n_checks++; if (s0_ready !== 1'b0) $display("FAIL kc_s0_blocked got %0b exp 0", s0_ready); else n_pass++;
      n_checks++; if (key_ready !== 1'b1) $display("FAIL kc_key_ready got %0b exp 1", key_ready); else n_pass++;
      advance();
      drive(1, 0, d, '0, 0, '0, 1);
      n_checks++; if (core_key !== nk) $display("FAIL kc_key_new got %h exp %h", core_key, nk); else n_pass++;
      n_checks++; if (s0_ready !== 1'b1) $display("FAIL kc_s0_next got %0b exp 1", s0_ready); else n_pass++;
      advance();
      drive(0, 0, '0, '0, 1, ok, 1);
      n_checks++; if (key_ready !== 1'b0) $display("FAIL kc_run_key_ready got %0b exp 0", key_ready); else n_pass++;
      advance();
      n_checks++; if (core_key !== nk) $display("FAIL kc_run_key got %h exp %h", core_key, nk); else n_pass++;
      for (int i = 0; i < 20 && ph != 0; i++) begin
         drive(0, 0, '0, '0, 0, '0, 1);
         if (exp_mv) begin
            n_checks++; if (m_data !== (d ^ nk)) $display("FAIL kc_result got %h exp %h", m_data, d ^ nk); else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_reset_midop();
      drive(1, 0, rnd128(), '0, 0, '0, 1);
      n_checks++; if (s0_ready !== 1'b1) $display("FAIL rm_s0_ready got %0b exp 1", s0_ready); else n_pass++;
      advance();
      drive(0, 0, '0, '0, 0, '0, 1);
      advance();
      rst = 1'b1;
      s0_valid = 0; s1_valid = 0; key_load = 0; m_ready = 1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL rm_abandon got v%0b busy%0b exp 00", m_valid, busy); else n_pass++;
      n_checks++; if (core_key !== '0 || core_data_in !== '0 || core_enc_dec !== 1'b0)
         $display("FAIL rm_core got key %h din %h ed %0b exp 0", core_key, core_data_in, core_enc_dec); else n_pass++;
      n_checks++; if (m_data !== '0 || m_id !== 1'b0)
         $display("FAIL rm_mout got %h id%0b exp 0", m_data, m_id); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, '0, '0, 0, '0, 1);
         n_checks++; if (m_valid !== 1'b0) $display("FAIL rm_no_valid got %0b exp 0", m_valid); else n_pass++;
         advance();
      end
      drive(1, 1, rnd128(), rnd128(), 0, '0, 1);
      n_checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0)
         $display("FAIL rm_tie got %0b%0b exp 10", s0_ready, s1_ready); else n_pass++;
      advance();
      drain();
   endtask

   task automatic test_random();
      bit v0, v1, kl, mr;
      for (int i = 0; i < 400; i++) begin
         v0 = ($urandom_range(0, 2) != 0);
         v1 = ($urandom_range(0, 2) != 0);
         kl = ($urandom_range(0, 7) == 0);
         mr = ($urandom_range(0, 1) == 1);
         drive(v0, v1, rnd128(), rnd128(), kl, rnd128(), mr);
         n_checks++; if (s0_ready !== exp_r0 || s1_ready !== exp_r1)
            $display("FAIL rnd_ready cyc %0d got %0b%0b exp %0b%0b", cyc, s0_ready, s1_ready, exp_r0, exp_r1); else n_pass++;
         n_checks++; if (key_ready !== exp_kr || busy !== exp_busy)
            $display("FAIL rnd_status cyc %0d got kr%0b busy%0b exp kr%0b busy%0b", cyc, key_ready, busy, exp_kr, exp_busy); else n_pass++;
         n_checks++; if (m_valid !== exp_mv) $display("FAIL rnd_m_valid cyc %0d got %0b exp %0b", cyc, m_valid, exp_mv); else n_pass++;
         if (exp_mv) begin
            n_checks++; if (m_data !== mdl_res || m_id !== mdl_id)
               $display("FAIL rnd_result cyc %0d got %h id%0b exp %h id%0b", cyc, m_data, m_id, mdl_res, mdl_id); else n_pass++;
         end
         if (ph != 0) begin
            n_checks++; if (core_data_in !== mdl_din || core_enc_dec !== mdl_enc)
               $display("FAIL rnd_core_in cyc %0d got %h ed%0b exp %h ed%0b", cyc, core_data_in, core_enc_dec, mdl_din, mdl_enc); else n_pass++;
         end
         n_checks++; if (core_key !== mdl_key) $display("FAIL rnd_key cyc %0d got %h exp %h", cyc, core_key, mdl_key); else n_pass++;
         n_checks++; if (cnt_enc !== exp_ce || cnt_dec !== exp_cd)
            $display("FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", cyc, cnt_enc, cnt_dec, exp_ce, exp_cd); else n_pass++;
         advance();
      end
      drain();
   endtask

   task automatic send(input bit id);
      drive(!id, id, rnd128(), rnd128(), 0, '0, 1);
      advance();
      drain();
   endtask

   task automatic test_stats();
      do_reset();
      send(0); send(1); send(0); send(1); send(0);
      drive(0, 0, '0, '0, 0, '0, 1);
`ifdef AES_SCHED_STATS_EN
      n_checks++; if (cnt_enc !== 16'd3) $display("FAIL st_cnt_enc got %0d exp 3", cnt_enc); else n_pass++;
      n_checks++; if (cnt_dec !== 16'd2) $display("FAIL st_cnt_dec got %0d exp 2", cnt_dec); else n_pass++;
      force dut.cnt_enc_q = 16'hFFFF;
      advance();
      release dut.cnt_enc_q;
      mdl_ce = 65535;
      send(0);
      drive(0, 0, '0, '0, 0, '0, 1);
      n_checks++; if (cnt_enc !== 16'hFFFF) $display("FAIL st_sat got %h exp ffff", cnt_enc); else n_pass++;
      n_checks++; if (cnt_dec !== 16'd2) $display("FAIL st_dec_kept got %0d exp 2", cnt_dec); else n_pass++;
`else
      n_checks++; if (cnt_enc !== 16'd0) $display("FAIL st_cnt_enc_off got %0d exp 0", cnt_enc); else n_pass++;
      n_checks++; if (cnt_dec !== 16'd0) $display("FAIL st_cnt_dec_off got %0d exp 0", cnt_dec); else n_pass++;
`endif
      advance();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_encrypt();
      test_contention();
      test_backpressure();
      test_key_collision();
      test_reset_midop();
      test_random();
      test_stats();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end
endmodule
